gray_stream_conv: RTL and testbench
===================================

# gray_stream_conv

Parametrised, pipelined successor to the byte-serial grayscale converter. Accepts interleaved R,G,B samples of configurable width over a valid/ready stream from the source frame buffer. Converts each pixel to one gray sample using a selectable weighting mode and streams the result to the destination buffer with backpressure. Counts pixels per frame, flags the last pixel, and reports frame completion to the controller.

## Interface
- `DW`, default 8: sample width for R, G, B and gray.
- `IMG_W`, default 5: image width in pixels (≥1).
- `IMG_H`, default 5: image height in pixels (≥1).
- `WW`, default 8: weight width for mode 2.
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: one-cycle pulse; begins a frame when idle.
- `abort`, in, 1: level; flushes and returns to IDLE.
- `mode`, in, 2: 0 = BT.601 weights 77/150/29; 1 = equal weights 85/86/85; 2 = programmable; 3 = reserved, behaves as 0.
- `w_r`, `w_g`, `w_b`, in, WW each: mode 2 weights (÷256).
- `in_valid`, in, 1: input sample valid.
- `in_ready`, out, 1: converter accepts the sample.
- `in_data`, in, DW: sample in R, G, B order.
- `out_valid`, out, 1: gray sample valid.
- `out_ready`, in, 1: sink accepts.
- `out_data`, out, DW: gray sample.
- `out_last`, out, 1: high with the final pixel of a frame.
- `busy`, out, 1: frame in progress.
- `done`, out, 1: one-cycle pulse on frame completion.

## Operation
- FSM states are IDLE, RUN, and DRAIN.
- IDLE → RUN on `start` when `abort` is low. On this transition, `mode` and the weights are latched for the whole frame, and the channel and pixel counters are cleared.
- In RUN, a transfer occurs when `in_valid && in_ready`. A 2-bit channel counter steps 0→1→2→0 and stores R, G, then B.
- On the B transfer, the latched triple is passed to the MAC stage and the pixel counter increments.
- After pixel number IMG_W·IMG_H is captured, the FSM goes RUN → DRAIN. In DRAIN, `in_ready` is 0.
- DRAIN → IDLE on the handshake of the pixel with `out_last`. `done` pulses in the cycle after that handshake.
- Arithmetic: `sum = wr·R + wg·G + wb·B + 128`, with width DW+WW+2. Result is `sum >> 8`, saturated to 2^DW−1.
- `abort` in any state: go to IDLE next cycle. Clear counters, `out_valid`, and the pipeline. No `done` pulse.
- `start` while not IDLE is ignored.
- Reset values: `in_ready` 0, `out_valid` 0, `out_data` 0, `out_last` 0, `busy` 0, `done` 0. State is IDLE and all counters are 0.
- Reset mid-frame gives the same result as reset from IDLE. Partial pixels are discarded.

## Timing
- Pipeline has two stages: S1 registers the weighted products, S2 registers the rounded and saturated sum into `out_data`.
- Latency: B accepted at cycle t → `out_valid` at t+2, assuming no stall.
- Global advance enable is `en = !out_valid || out_ready`. S1 and S2 move only when `en` is high.
- `in_ready = (state == RUN) && en`. This is a registered-state term and has no combinational path from `in_valid`.
- With `out_ready` held high, throughput is one pixel per 3 cycles, matching the 3-sample input cadence.
- When `out_ready` is low, `out_data`, `out_valid` and `out_last` stay stable until the handshake.
- `busy` is 1 from the cycle after `start` until the cycle `done` is asserted.
- `out_last` is asserted only with `out_valid`, on pixel IMG_W·IMG_H.

## Structure
- Shared package `gray_pkg` holds:
  - mode encodings `GRAY_BT601`, `GRAY_EQUAL`, `GRAY_PROG`;
  - default weights 77/150/29 and 85/86/85;
  - the rounding constant 128.
- The FSM and counters live in `gray_stream_conv`.
- Sub-module `gray_mac` holds the weighted sum, rounding, saturation and S1/S2 registers. It is parametrised by DW and WW and takes `en`.

## Test plan
- Mode 0 basic: IMG 1×1, stream R=200, G=100, B=50 with `out_ready`=1. Expect `out_data`=124 at t+2 with `out_last`=1, then `done` one cycle after the handshake.
- Full scale: mode 0 with 255/255/255 gives 255, and 0/0/0 gives 0. Mode 1 with 255/255/255 gives 255.
- Saturation: mode 2, weights 255/255/255, input 255/255/255. The raw value is 762, so expect 255.
- Backpressure: 5×5 frame with `out_ready` toggling randomly, including 10-cycle low stretches. Expect:
  - exactly 25 outputs, in order;
  - `out_data` stable while stalled;
  - `in_ready` low while `out_valid && !out_ready`;
  - `out_last` only on output 25.
- Abort and reset: assert `abort` after pixel 7 is accepted, and check IDLE the next cycle, `out_valid`=0 and no `done`. Repeat with `rst_n` low mid-frame and check all outputs at their reset values. A new `start` must then run a clean frame.
- Mode latch: change `mode` and weights during RUN. Outputs must use the values latched at `start`.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared definitions for the streaming RGB-to-gray converter: mode codes,
// fixed weight sets, the rounding constant and the controller state type.
package gray_pkg;

    localparam logic [1:0] GRAY_BT601 = 2'd0;
    localparam logic [1:0] GRAY_EQUAL = 2'd1;
    localparam logic [1:0] GRAY_PROG  = 2'd2;

    localparam int BT601_WR = 77;
    localparam int BT601_WG = 150;
    localparam int BT601_WB = 29;

    localparam int EQUAL_WR = 85;
    localparam int EQUAL_WG = 86;
    localparam int EQUAL_WB = 85;

    localparam int GRAY_RND = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } gray_state_e;

endpackage

// File: rtl/gray_stream_conv_mac.sv
// Two-stage weighted-sum datapath: S1 holds the three products, S2 holds the
// rounded, saturated gray sample. Both stages advance only on en.
module gray_mac
    import gray_pkg::*;
#(
    parameter int DW = 8,
    parameter int WW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          flush,
    input  logic          in_vld,
    input  logic          in_last,
    input  logic [DW-1:0] r,
    input  logic [DW-1:0] g,
    input  logic [DW-1:0] b,
    input  logic [WW-1:0] wr,
    input  logic [WW-1:0] wg,
    input  logic [WW-1:0] wb,
    output logic          out_valid,
    output logic          out_last,
    output logic [DW-1:0] out_data
);

    localparam int PW = DW + WW;
    localparam int SW = DW + WW + 2;

    logic [PW-1:0] prod_r_p1, prod_g_p1, prod_b_p1;
    logic          vld_p1, last_p1;

    function automatic logic [DW-1:0] round_sat(input logic [PW-1:0] a,
                                                input logic [PW-1:0] c,
                                                input logic [PW-1:0] d);
        logic [SW-1:0] sum;
        logic [SW-1:0] q;
        sum = SW'(a) + SW'(c) + SW'(d) + SW'(GRAY_RND);
        q   = sum >> 8;
        if (|(q >> DW)) return '1;
        return q[DW-1:0];
    endfunction

    // S1: weighted products
    always_ff @(posedge clk) begin
        if (en) begin
            prod_r_p1 <= PW'(r) * PW'(wr);
            prod_g_p1 <= PW'(g) * PW'(wg);
            prod_b_p1 <= PW'(b) * PW'(wb);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else if (en) begin
            vld_p1  <= in_vld;
            last_p1 <= in_vld && in_last;
        end
    end

    // S2: rounded and saturated output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (en) begin
            out_valid <= vld_p1;
            out_last  <= last_p1;
            if (vld_p1) out_data <= round_sat(prod_r_p1, prod_g_p1, prod_b_p1);
        end
    end

endmodule

// File: rtl/gray_stream_conv.sv
// Frame controller for the gray converter: gathers R,G,B samples into pixels,
// counts pixels per frame and hands each completed pixel to gray_mac.
module gray_stream_conv
    import gray_pkg::*;
#(
    parameter int DW    = 8,
    parameter int IMG_W = 5,
    parameter int IMG_H = 5,
    parameter int WW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [1:0]    mode,
    input  logic [WW-1:0] w_r,
    input  logic [WW-1:0] w_g,
    input  logic [WW-1:0] w_b,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int PCW  = $clog2(NPIX + 1);

    gray_state_e   state, state_nx;
    logic [1:0]    ch_cnt;
    logic [PCW-1:0] pix_cnt;
    logic [DW-1:0] r_q, g_q;
    logic [WW-1:0] wr_q, wg_q, wb_q;
    logic          en, xfer, b_xfer, last_px, last_hs, go;

    assign en       = !out_valid || out_ready;
    assign in_ready = (state == ST_RUN) && en;
    assign xfer     = in_valid && in_ready;
    assign b_xfer   = xfer && (ch_cnt == 2'd2);
    assign last_px  = (pix_cnt == PCW'(NPIX - 1));
    assign last_hs  = out_valid && out_ready && out_last;
    assign go       = (state == ST_IDLE) && start && !abort;
    assign busy     = (state != ST_IDLE);

    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start) state_nx = ST_RUN;
                ST_RUN:   if (b_xfer && last_px) state_nx = ST_DRAIN;
                ST_DRAIN: if (last_hs) state_nx = ST_IDLE;
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ch_cnt  <= 2'd0;
            pix_cnt <= '0;
            done    <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= (state == ST_DRAIN) && last_hs && !abort;
            if (abort || go) begin
                ch_cnt  <= 2'd0;
                pix_cnt <= '0;
            end else if (xfer) begin
                ch_cnt <= b_xfer ? 2'd0 : ch_cnt + 2'd1;
                if (b_xfer) pix_cnt <= pix_cnt + 1'b1;
            end
        end
    end

    // Weights are frozen at start so mid-frame mode changes cannot mix sets.
    always_ff @(posedge clk) begin
        if (go) begin
            case (mode)
                GRAY_EQUAL: begin
                    wr_q <= WW'(EQUAL_WR); wg_q <= WW'(EQUAL_WG); wb_q <= WW'(EQUAL_WB);
                end
                GRAY_PROG: begin
                    wr_q <= w_r; wg_q <= w_g; wb_q <= w_b;
                end
                default: begin
                    wr_q <= WW'(BT601_WR); wg_q <= WW'(BT601_WG); wb_q <= WW'(BT601_WB);
                end
            endcase
        end
        if (xfer && ch_cnt == 2'd0) r_q <= in_data;
        if (xfer && ch_cnt == 2'd1) g_q <= in_data;
    end

    gray_mac #(.DW(DW), .WW(WW)) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .flush    (abort),
        .in_vld   (b_xfer),
        .in_last  (last_px),
        .r        (r_q),
        .g        (g_q),
        .b        (in_data),
        .wr       (wr_q),
        .wg       (wg_q),
        .wb       (wb_q),
        .out_valid(out_valid),
        .out_last (out_last),
        .out_data (out_data)
    );

endmodule

// File: tb/tb_gray_stream_conv.sv
// Bench for gray_stream_conv: a 1x1 instance for single-pixel arithmetic and
// timing, and a 5x5 instance for frame, backpressure, abort and reset behaviour.
module tb_gray_stream_conv;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       abort;
    logic [1:0] mode;
    logic [7:0] w_r, w_g, w_b;

    logic       a_start, a_in_valid, a_out_ready;
    logic [7:0] a_in_data;
    logic       a_in_ready, a_out_valid, a_out_last, a_busy, a_done;
    logic [7:0] a_out_data;

    logic       b_start, b_in_valid, b_out_ready;
    logic [7:0] b_in_data;
    logic       b_in_ready, b_out_valid, b_out_last, b_busy, b_done;
    logic [7:0] b_out_data;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gray_stream_conv #(.DW(8), .IMG_W(1), .IMG_H(1), .WW(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .abort(abort), .mode(mode),
        .w_r(w_r), .w_g(w_g), .w_b(w_b),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_last(a_out_last), .busy(a_busy), .done(a_done)
    );

    gray_stream_conv #(.DW(8), .IMG_W(5), .IMG_H(5), .WW(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .abort(abort), .mode(mode),
        .w_r(w_r), .w_g(w_g), .w_b(w_b),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_last(b_out_last), .busy(b_busy), .done(b_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: weighted sum over 256 with half-up rounding, clipped to 8 bits.
    function automatic int model(input int md, input int wr, input int wg, input int wb,
                                 input int r, input int g, input int b);
        int kr, kg, kb, v;
        case (md)
            1: begin kr = 85; kg = 86; kb = 85; end
            2: begin kr = wr; kg = wg; kb = wb; end
            default: begin kr = 77; kg = 150; kb = 29; end
        endcase
        v = (kr * r + kg * g + kb * b + 128) / 256;
        if (v > 255) v = 255;
        return v;
    endfunction

    task automatic scramble_cfg();
        mode = 2'($urandom_range(0, 3));
        w_r  = 8'($urandom_range(0, 255));
        w_g  = 8'($urandom_range(0, 255));
        w_b  = 8'($urandom_range(0, 255));
    endtask

    task automatic run_px(input string tag, input int md, input int wr, input int wg,
                          input int wb, input int r, input int g, input int b);
        int s[3];
        int e;
        s[0] = r; s[1] = g; s[2] = b;
        e = model(md, wr, wg, wb, r, g, b);
        @(negedge clk);
        mode = 2'(md); w_r = 8'(wr); w_g = 8'(wg); w_b = 8'(wb);
        a_start = 1'b1; a_out_ready = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        scramble_cfg();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            a_in_valid = 1'b1;
            a_in_data  = 8'(s[i]);
            #4;
            if (i == 0) chk({tag, "_busy"}, a_busy, 1);
            chk({tag, "_inrdy"}, a_in_ready, 1);
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        #4 chk({tag, "_vld_t1"}, a_out_valid, 0);
        @(negedge clk);
        #4;
        chk({tag, "_vld_t2"}, a_out_valid, 1);
        chk({tag, "_data"}, a_out_data, e);
        chk({tag, "_last"}, a_out_last, 1);
        @(negedge clk);
        #4;
        chk({tag, "_done"}, a_done, 1);
        chk({tag, "_busy_end"}, a_busy, 0);
        chk({tag, "_vld_end"}, a_out_valid, 0);
        @(negedge clk);
        #4 chk({tag, "_done_pulse"}, a_done, 0);
    endtask

    task automatic chk_b_reset(input string tag);
        chk({tag, "_inrdy"}, b_in_ready, 0);
        chk({tag, "_ovld"}, b_out_valid, 0);
        chk({tag, "_odata"}, b_out_data, 0);
        chk({tag, "_olast"}, b_out_last, 0);
        chk({tag, "_busy"}, b_busy, 0);
        chk({tag, "_done"}, b_done, 0);
    endtask

    // stop_mode: 0 = complete frame, 1 = abort after pixel 7, 2 = reset after pixel 7
    task automatic run_frame(input string tag, input bit bp, input bit chg, input int stop_mode);
        logic [7:0] samp[75];
        int expq[25];
        int md, wr, wg, wb;
        int k, pix, nout, cyc, stretch;
        bit fin, stall, last_prev, stop;
        logic [7:0] held_data;
        logic held_last;

        md = $urandom_range(0, 3);
        wr = $urandom_range(0, 255); wg = $urandom_range(0, 255); wb = $urandom_range(0, 255);
        for (int i = 0; i < 75; i++) samp[i] = 8'($urandom_range(0, 255));
        for (int p = 0; p < 25; p++)
            expq[p] = model(md, wr, wg, wb, samp[3*p], samp[3*p+1], samp[3*p+2]);

        @(negedge clk);
        mode = 2'(md); w_r = 8'(wr); w_g = 8'(wg); w_b = 8'(wb);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        #4 chk({tag, "_busy"}, b_busy, 1);

        k = 0; pix = 0; nout = 0; cyc = 0; stretch = 0;
        fin = 0; stall = 0; last_prev = 0; stop = 0;
        held_data = '0; held_last = 1'b0;
        while (!fin && !stop && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (chg) scramble_cfg();
            b_in_valid = (k < 75) && ($urandom_range(0, 3) != 0);
            if (k < 75) b_in_data = samp[k];
            if (!bp) b_out_ready = 1'b1;
            else if (stretch > 0) begin b_out_ready = 1'b0; stretch--; end
            else if ($urandom_range(0, 15) == 0) begin b_out_ready = 1'b0; stretch = 9; end
            else b_out_ready = 1'($urandom_range(0, 1));
            #4;
            if (stall) begin
                chk({tag, "_stall_vld"}, b_out_valid, 1);
                chk({tag, "_stall_data"}, b_out_data, held_data);
                chk({tag, "_stall_last"}, b_out_last, held_last);
            end
            if (b_out_last) chk({tag, "_last_vld"}, b_out_valid, 1);
            if (b_out_valid && !b_out_ready) chk({tag, "_inrdy_stall"}, b_in_ready, 0);
            chk({tag, "_done"}, b_done, last_prev);
            if (last_prev) begin
                chk({tag, "_busy_end"}, b_busy, 0);
                fin = 1;
            end
            last_prev = 0;
            stall = b_out_valid && !b_out_ready;
            held_data = b_out_data;
            held_last = b_out_last;
            if (b_in_valid && b_in_ready) begin
                k++;
                if (k % 3 == 0) pix++;
            end
            if (b_out_valid && b_out_ready) begin
                if (nout < 25) chk({tag, "_data"}, b_out_data, expq[nout]);
                else chk({tag, "_extra_out"}, nout, 24);
                chk({tag, "_olast"}, b_out_last, (nout == 24));
                if (b_out_last) last_prev = 1;
                nout++;
            end
            if (stop_mode != 0 && pix == 7) stop = 1;
        end

        if (stop_mode == 0) begin
            chk({tag, "_finished"}, fin, 1);
            chk({tag, "_count"}, nout, 25);
        end else begin
            chk({tag, "_reached_px7"}, stop, 1);
            @(negedge clk);
            b_in_valid = 1'b0;
            b_out_ready = 1'b1;
            if (stop_mode == 1) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                #4;
                chk({tag, "_ab_busy"}, b_busy, 0);
                chk({tag, "_ab_ovld"}, b_out_valid, 0);
                chk({tag, "_ab_inrdy"}, b_in_ready, 0);
            end else begin
                rst_n = 1'b0;
                #1 chk_b_reset({tag, "_rst"});
                @(negedge clk);
                rst_n = 1'b1;
                #4 chk_b_reset({tag, "_rstrel"});
            end
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                #4;
                chk({tag, "_nodone"}, b_done, 0);
                chk({tag, "_noovld"}, b_out_valid, 0);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; abort = 1'b0; mode = 2'd0;
        w_r = 8'd0; w_g = 8'd0; w_b = 8'd0;
        a_start = 1'b0; a_in_valid = 1'b0; a_in_data = 8'd0; a_out_ready = 1'b1;
        b_start = 1'b0; b_in_valid = 1'b0; b_in_data = 8'd0; b_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_b_reset("reset");
        chk("reset_a_ovld", a_out_valid, 0);
        chk("reset_a_inrdy", a_in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_px("bt601_basic", 0, 0, 0, 0, 200, 100, 50);
        run_px("bt601_white", 0, 0, 0, 0, 255, 255, 255);
        run_px("bt601_black", 0, 0, 0, 0, 0, 0, 0);
        run_px("equal_white", 1, 0, 0, 0, 255, 255, 255);
        run_px("prog_sat", 2, 255, 255, 255, 255, 255, 255);
        run_px("mode3", 3, 255, 0, 255, 10, 240, 90);
        for (int i = 0; i < 6; i++)
            run_px("rand_px", $urandom_range(0, 3), $urandom_range(0, 255),
                   $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                   $urandom_range(0, 255), $urandom_range(0, 255));

        run_frame("frame", 1'b0, 1'b0, 0);
        run_frame("bp", 1'b1, 1'b0, 0);
        run_frame("latch", 1'b1, 1'b1, 0);
        run_frame("abort", 1'b0, 1'b0, 1);
        run_frame("post_abort", 1'b1, 1'b0, 0);
        run_frame("rstmid", 1'b0, 1'b0, 2);
        run_frame("post_rst", 1'b1, 1'b1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
